collision_scan_ctrl: RTL
========================

COLLISION_SCAN_CTRL -- requirements
Module: collision_scan_ctrl

Interface
REQ-001 Parameter DATAWIDTH_SELECTOR, default 3, SHALL set the lane-select width.
REQ-002 Parameter DATAWIDTH_DATA, default 8, SHALL set the lane count (2**DATAWIDTH_SELECTOR).
REQ-003 ColScan_CLOCK_50  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 ColScan_RESET_InHigh  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 ColScan_Start_InHigh  input  1  SHALL request one full scan; sampled only in IDLE.
REQ-006 ColScan_Abort_InHigh  input  1  SHALL cancel a scan in progress.
REQ-007 ColScan_LaneMask_Bus_In  input  DATAWIDTH_DATA  SHALL mark lanes to check (1 = check).
REQ-008 ColScan_MuxBit_In  input  1  SHALL be the selected-lane occupancy bit returned by the external 8:1 lane mux.
REQ-009 ColScan_Select_Bus_Out  output  DATAWIDTH_SELECTOR  SHALL drive the external mux select.
REQ-010 ColScan_Busy_OutHigh  output  1  SHALL be high while a scan is in progress.
REQ-011 ColScan_Done_OutHigh  output  1  SHALL pulse one cycle when results update.
REQ-012 ColScan_Hit_Bus_Out  output  DATAWIDTH_DATA  SHALL hold the per-lane hit vector of the last completed scan.
REQ-013 ColScan_Collision_OutHigh  output  1  SHALL be the OR of ColScan_Hit_Bus_Out.
REQ-014 ColScan_Lane_Bus_Out  output  DATAWIDTH_SELECTOR  SHALL hold the lowest hit lane index (0 if no hit).

Function
REQ-015 FSM states SHALL be IDLE, SETUP, SAMPLE, DONE; all outputs registered.
REQ-016 IDLE: Start high SHALL capture LaneMask into an internal mask register, clear the working hit vector, set Select=0, go SETUP.
REQ-017 SETUP SHALL hold Select stable one cycle (mux settle), then go SAMPLE.
REQ-018 SAMPLE SHALL set working hit[Select] = mask[Select] AND MuxBit.
REQ-019 SAMPLE with Select < DATAWIDTH_DATA-1 SHALL increment Select and go SETUP; with Select = DATAWIDTH_DATA-1 SHALL go DONE, Select unchanged.
REQ-020 DONE SHALL load Hit, Collision, Lane from the working vector, assert Done for that cycle only, set Select=0, go IDLE.
REQ-021 Latency: start sampled at edge N SHALL give Done high in cycle N+17 (default parameters), i.e. 2 cycles per lane plus 1.
REQ-022 Busy SHALL be high in SETUP, SAMPLE and DONE, low in IDLE.
REQ-023 Start while not IDLE SHALL be ignored (no queuing).
REQ-024 Abort high in SETUP or SAMPLE SHALL force IDLE next edge, Select=0, no Done, Hit/Collision/Lane unchanged.
REQ-025 Abort in IDLE or DONE SHALL have no effect; Start and Abort together in IDLE SHALL start a scan.
REQ-026 LaneMask changes during a scan SHALL not affect it (captured mask used).
REQ-027 Mask all zero SHALL still run a full 17-cycle scan and report Collision=0, Hit=0, Lane=0.
REQ-028 Multiple hits SHALL report Lane as the lowest set index.

Reset
REQ-029 Reset high SHALL immediately force IDLE, Select=0, Busy=0, Done=0, Hit=0, Collision=0, Lane=0, mask and working vector 0.
REQ-030 Reset asserted mid-scan SHALL discard the scan with no Done pulse; first scan after release starts only on a new Start.

Verification
REQ-031 Mask=8'hFF, MuxBit high only when Select=5, Start pulse -> Done 17 cycles later, Hit=8'h20, Collision=1, Lane=5.
REQ-032 Mask=8'h0F, MuxBit high when Select=2 or 6 -> Hit=8'h04, Lane=2, Collision=1.
REQ-033 Mask=8'h00, MuxBit constant 1 -> Done after 17 cycles, Hit=0, Collision=0, Lane=0.
REQ-034 Completed scan (Hit=8'h20), then new Start with Abort at cycle 6 -> no Done, Busy low next cycle, Hit still 8'h20.
REQ-035 Start repeated every cycle during a scan -> exactly one Done per 18 cycles, Select sequence 0..7 each held 2 cycles.
REQ-036 Reset pulse at cycle 9 of scan -> all outputs 0 immediately, no Done afterwards without new Start.

Source files
------------

// File: rtl/collision_scan_ctrl.sv
// -----------------------------------------------------------------------------
// collision_scan_ctrl
//
// Walks an external N:1 lane-occupancy mux one lane at a time and builds a
// per-lane hit vector (occupied AND enabled by the captured lane mask). Each
// lane takes two cycles: one to let the mux settle on a new select value and
// one to sample its output. One cycle at the end publishes the results. With
// the default 8 lanes, Done rises 17 cycles after the edge that accepts Start.
//
// Ports
//   ColScan_CLOCK_50          in   single clock, rising edge
//   ColScan_RESET_InHigh      in   asynchronous active-high reset
//   ColScan_Start_InHigh      in   request one full scan (accepted in IDLE only)
//   ColScan_Abort_InHigh      in   cancel a scan while it is walking the lanes
//   ColScan_LaneMask_Bus_In   in   lanes to check, captured when Start is accepted
//   ColScan_MuxBit_In         in   occupancy bit of the currently selected lane
//   ColScan_Select_Bus_Out    out  select for the external lane mux
//   ColScan_Busy_OutHigh      out  high while a scan is in progress
//   ColScan_Done_OutHigh      out  one-cycle pulse when the result outputs update
//   ColScan_Hit_Bus_Out       out  hit vector of the last completed scan
//   ColScan_Collision_OutHigh out  OR of the hit vector
//   ColScan_Lane_Bus_Out      out  lowest hit lane index (0 when no hit)
// -----------------------------------------------------------------------------
module collision_scan_ctrl #(
  parameter int DATAWIDTH_SELECTOR = 3,
  parameter int DATAWIDTH_DATA     = 8
) (
  input  logic                          ColScan_CLOCK_50,
  input  logic                          ColScan_RESET_InHigh,
  input  logic                          ColScan_Start_InHigh,
  input  logic                          ColScan_Abort_InHigh,
  input  logic [DATAWIDTH_DATA-1:0]     ColScan_LaneMask_Bus_In,
  input  logic                          ColScan_MuxBit_In,
  output logic [DATAWIDTH_SELECTOR-1:0] ColScan_Select_Bus_Out,
  output logic                          ColScan_Busy_OutHigh,
  output logic                          ColScan_Done_OutHigh,
  output logic [DATAWIDTH_DATA-1:0]     ColScan_Hit_Bus_Out,
  output logic                          ColScan_Collision_OutHigh,
  output logic [DATAWIDTH_SELECTOR-1:0] ColScan_Lane_Bus_Out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [DATAWIDTH_SELECTOR-1:0] LAST_LANE =
    DATAWIDTH_SELECTOR'(DATAWIDTH_DATA - 1);

  logic [1:0]                    state;
  logic [DATAWIDTH_DATA-1:0]     mask;      // lane mask frozen for the whole scan
  logic [DATAWIDTH_DATA-1:0]     work;      // hit vector being assembled
  logic [DATAWIDTH_SELECTOR-1:0] lowest_lane;

  // Lowest set index of the working vector; walking from the top down lets
  // the last assignment win, which is the lowest hit.
  // NOTE: the default assignment before the loop keeps this purely
  // combinational; without it a vector with no bits set would infer a latch.
  always_comb begin
    lowest_lane = '0;
    for (int i = DATAWIDTH_DATA - 1; i >= 0; i--) begin
      if (work[i]) lowest_lane = DATAWIDTH_SELECTOR'(i);
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge ColScan_CLOCK_50 or posedge ColScan_RESET_InHigh) begin
    if (ColScan_RESET_InHigh) begin
      state                     <= S_IDLE;
      mask                      <= '0;
      work                      <= '0;
      ColScan_Select_Bus_Out    <= '0;
      ColScan_Busy_OutHigh      <= 1'b0;
      ColScan_Done_OutHigh      <= 1'b0;
      ColScan_Hit_Bus_Out       <= '0;
      ColScan_Collision_OutHigh <= 1'b0;
      ColScan_Lane_Bus_Out      <= '0;
    end else begin
      ColScan_Done_OutHigh <= 1'b0;

      case (state)
        S_IDLE: begin
          // Abort is irrelevant here, so Start+Abort together still starts.
          if (ColScan_Start_InHigh) begin
            mask                   <= ColScan_LaneMask_Bus_In;
            work                   <= '0;
            ColScan_Select_Bus_Out <= '0;
            ColScan_Busy_OutHigh   <= 1'b1;
            state                  <= S_SETUP;
          end
        end

        S_SETUP: begin
          // Select is held for this cycle so the external mux can settle.
          if (ColScan_Abort_InHigh) begin
            ColScan_Select_Bus_Out <= '0;
            ColScan_Busy_OutHigh   <= 1'b0;
            state                  <= S_IDLE;
          end else begin
            state <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          if (ColScan_Abort_InHigh) begin
            ColScan_Select_Bus_Out <= '0;
            ColScan_Busy_OutHigh   <= 1'b0;
            state                  <= S_IDLE;
          end else begin
            work[ColScan_Select_Bus_Out] <= mask[ColScan_Select_Bus_Out] & ColScan_MuxBit_In;
            if (ColScan_Select_Bus_Out == LAST_LANE) begin
              state <= S_DONE;
            end else begin
              ColScan_Select_Bus_Out <= ColScan_Select_Bus_Out + DATAWIDTH_SELECTOR'(1);
              state                  <= S_SETUP;
            end
          end
        end

        S_DONE: begin
          // Results publish here; Abort and Start are both ignored.
          ColScan_Hit_Bus_Out       <= work;
          ColScan_Collision_OutHigh <= |work;
          ColScan_Lane_Bus_Out      <= lowest_lane;
          ColScan_Done_OutHigh      <= 1'b1;
          ColScan_Select_Bus_Out    <= '0;
          ColScan_Busy_OutHigh      <= 1'b0;
          state                     <= S_IDLE;
        end

        default: begin
          ColScan_Select_Bus_Out <= '0;
          ColScan_Busy_OutHigh   <= 1'b0;
          state                  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
